// File: rtl/mem_instr_sequencer.sv
// Hardwired Moore control sequencer for ld/ldi/st: fetch T0-T2, execute T3-T7,
// memory-ready handshake with timeout. Optional SINGLE_STEP_EN adds a step_en gate.
module mem_instr_sequencer #(
  parameter int             OPC_W   = 5,
  parameter logic [OPC_W-1:0] LD_OPC  = 5'b00000,
  parameter logic [OPC_W-1:0] LDI_OPC = 5'b00001,
  parameter logic [OPC_W-1:0] ST_OPC  = 5'b00010,
  parameter int             TMO_W   = 4,
  parameter int             TMO_MAX = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
`ifdef SINGLE_STEP_EN
  input  logic             step_en,
`endif
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             PCin,
  output logic             ram_read,
  output logic             ram_write,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             Yin,
  output logic             Cout,
  output logic             Zlowout,
  output logic             alu_add,
  output logic             busy,
  output logic             done,
  output logic             err_illegal,
  output logic             err_timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {K_LD, K_LDI, K_ST} kind_t;

  state_t           state, state_nx;
  kind_t            kind, dec_kind;
  logic [TMO_W-1:0] cnt;
  logic             adv, legal, mem_step, tmo_hit;

`ifdef SINGLE_STEP_EN
  assign adv = step_en;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    legal    = 1'b1;
    dec_kind = K_LD;
    if (ir_opcode == LD_OPC)       dec_kind = K_LD;
    else if (ir_opcode == LDI_OPC) dec_kind = K_LDI;
    else if (ir_opcode == ST_OPC)  dec_kind = K_ST;
    else                           legal    = 1'b0;
  end

  // Timeout fires on the cycle the wait count would reach TMO_MAX with no ready.
  assign mem_step = (state == S_T1) ||
                    (state == S_T6 && kind == K_LD) ||
                    (state == S_T7 && kind == K_ST);
  assign tmo_hit  = mem_step && adv && !mem_ready && (cnt == TMO_W'(TMO_MAX - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_T0;
      S_T0:   if (adv) state_nx = S_T1;
      S_T1:   if (adv && mem_ready) state_nx = S_T2;
      S_T2:   if (adv) state_nx = S_T3;
      S_T3:   if (adv) state_nx = legal ? S_T4 : S_ERR;
      S_T4:   if (adv) state_nx = S_T5;
      S_T5:   if (adv) state_nx = (kind == K_LDI) ? S_DONE : S_T6;
      S_T6:   if (adv && (kind == K_ST || mem_ready)) state_nx = S_T7;
      S_T7:   if (adv && (kind == K_LD || mem_ready)) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      S_ERR:  state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
    if (tmo_hit) state_nx = S_ERR;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= S_IDLE;
      kind        <= K_LD;
      cnt         <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_T3 && adv) begin
        if (legal) kind <= dec_kind;
        else       err_illegal <= 1'b1;
      end
      if (tmo_hit) err_timeout <= 1'b1;
      if (!mem_step)                          cnt <= '0;
      else if (adv && !mem_ready && !tmo_hit) cnt <= cnt + TMO_W'(1);
    end
  end

  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0; PCin = 1'b0;
    ram_read = 1'b0; ram_write = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Yin = 1'b0;
    Cout = 1'b0; Zlowout = 1'b0; alu_add = 1'b0;
    busy = (state != S_IDLE);
    done = (state == S_DONE);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; ram_read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      S_T4: begin Cout = 1'b1; alu_add = 1'b1; Zin = 1'b1; end
      S_T5: begin
        Zlowout = 1'b1;
        if (kind == K_LDI) begin Gra = 1'b1; Rin = 1'b1; end
        else               MARin = 1'b1;
      end
      S_T6: begin
        MDRin = 1'b1;
        if (kind == K_ST) begin Gra = 1'b1; Rout = 1'b1; end
        else              ram_read = 1'b1;
      end
      S_T7: begin
        if (kind == K_ST) ram_write = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// Scoreboard bench for mem_instr_sequencer: expected per-cycle output vectors are
// queued as stimulus is driven and compared on the falling edge.
module tb_mem_instr_sequencer;

  localparam int SI = 0, S0 = 1, S1 = 2, S2 = 3, S3 = 4, S4 = 5, S5 = 6, S6 = 7,
                 S7 = 8, SD = 9, SE = 10;
  localparam int KLD = 0, KLDI = 1, KST = 2, KBAD = 3;

  logic       clock, clear, start, mem_ready;
  logic [4:0] ir_opcode;
  logic PCout, MARin, IncPC, Zin, PCin, ram_read, ram_write, MDRin, MDRout, IRin;
  logic Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowout, alu_add;
  logic busy, done, err_illegal, err_timeout;
`ifdef SINGLE_STEP_EN
  logic step_en;
  assign step_en = 1'b1;
`endif

  mem_instr_sequencer dut (
    .clock(clock), .clear(clear), .start(start),
`ifdef SINGLE_STEP_EN
    .step_en(step_en),
`endif
    .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
    .ram_read(ram_read), .ram_write(ram_write), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yin(Yin), .Cout(Cout), .Zlowout(Zlowout), .alu_add(alu_add), .busy(busy),
    .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  logic [22:0] obs;
  assign obs = {PCout, MARin, IncPC, Zin, PCin, ram_read, ram_write, MDRin, MDRout,
                IRin, Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowout, alu_add,
                busy, done, err_illegal, err_timeout};

  int unsigned total = 0, bad = 0;
  logic [22:0] sb_q[$];
  int  mk;
  bit  fi, ft;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [22:0] got, input logic [22:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  function automatic logic [22:0] model(input int s, input int k, input bit ei, input bit et);
    logic pco, mar, inc, zin, pcin, rr, rw, mdi, mdo, iri, gra, grb, rin, rout, ba, yin, cout, zlo, add;
    {pco, mar, inc, zin, pcin, rr, rw, mdi, mdo, iri, gra, grb, rin, rout, ba, yin, cout, zlo, add} = '0;
    case (s)
      S0: begin pco = 1; mar = 1; inc = 1; zin = 1; end
      S1: begin zlo = 1; pcin = 1; rr = 1; mdi = 1; end
      S2: begin mdo = 1; iri = 1; end
      S3: begin grb = 1; ba = 1; yin = 1; end
      S4: begin cout = 1; add = 1; zin = 1; end
      S5: begin zlo = 1; if (k == KLDI) begin gra = 1; rin = 1; end else mar = 1; end
      S6: if (k == KLD) begin rr = 1; mdi = 1; end else begin gra = 1; rout = 1; mdi = 1; end
      S7: if (k == KLD) begin mdo = 1; gra = 1; rin = 1; end else rw = 1;
      default: ;
    endcase
    return {pco, mar, inc, zin, pcin, rr, rw, mdi, mdo, iri, gra, grb, rin, rout, ba,
            yin, cout, zlo, add, (s != SI), (s == SD), ei, et};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One cycle: queue expected outputs for state s, compare on negedge, then drive inputs.
  task automatic cyc(input int s, input logic st_in, input logic mr);
    logic [22:0] want;
    sb_q.push_back(model(s, mk, fi, ft));
    @(negedge clock);
    want = sb_q.pop_front();
    check($sformatf("state%0d", s), obs, want);
    start     = st_in;
    mem_ready = mr;
  endtask

  task automatic rst_pulse();
    clear = 1'b0;
    start = 1'b0;
    fi = 0; ft = 0;
    #1;
    check("async_clear", obs, 23'd0);
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
  endtask

  task automatic run(input logic [4:0] opc, input int k, input int w1, input int w2, input bit hs);
    ir_opcode = opc;
    mk = k;
    cyc(SI, 1'b1, rb());
    cyc(S0, hs, rb());
    for (int i = 0; i < w1; i++) cyc(S1, hs, 1'b0);
    cyc(S1, hs, 1'b1);
    cyc(S2, hs, rb());
    if (k == KBAD) begin
      cyc(S3, hs, rb());
      fi = 1;
      repeat (4) cyc(SE, 1'b1, rb());
      return;
    end
    cyc(S3, hs, rb());
    cyc(S4, hs, rb());
    if (k == KLDI) begin
      cyc(S5, hs, rb());
      cyc(SD, hs, rb());
      return;
    end
    cyc(S5, hs, rb());
    if (k == KST) cyc(S6, hs, rb());
    for (int i = 0; i < w2; i++) begin
      cyc((k == KLD) ? S6 : S7, hs, 1'b0);
      if (i == 14) begin
        ft = 1;
        repeat (3) cyc(SE, 1'b1, rb());
        return;
      end
    end
    if (k == KLD) begin
      cyc(S6, hs, 1'b1);
      cyc(S7, hs, rb());
    end else begin
      cyc(S7, hs, 1'b1);
    end
    cyc(SD, hs, rb());
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir_opcode = '0;
    mk = KLD; fi = 0; ft = 0;
    #12;
    check("reset_state", obs, 23'd0);
    @(negedge clock);
    clear = 1'b1;

    run(5'b00001, KLDI, 0, 0, 1'b0);
    run(5'b00000, KLD, 3, 2, 1'b0);
    run(5'b00010, KST, 0, 1, 1'b0);
    run(5'b00001, KLDI, 0, 0, 1'b1);
    run(5'b00000, KLD, 0, 0, 1'b1);
    run(5'b00010, KST, 2, 0, 1'b0);

    run(5'b11111, KBAD, 0, 0, 1'b0);
    rst_pulse();

    run(5'b00000, KLD, 0, 15, 1'b0);
    rst_pulse();
    run(5'b00000, KLD, 0, 14, 1'b0);
    run(5'b00010, KST, 0, 15, 1'b0);
    rst_pulse();

    ir_opcode = 5'b00000;
    mk = KLD;
    cyc(SI, 1'b1, rb());
    cyc(S0, 1'b0, rb());
    cyc(S1, 1'b0, 1'b1);
    cyc(S2, 1'b0, rb());
    cyc(S3, 1'b0, rb());
    cyc(S4, 1'b0, rb());
    rst_pulse();
    run(5'b00001, KLDI, 0, 0, 1'b0);
    cyc(SI, 1'b0, 1'b0);

    check("sb_empty", 23'(sb_q.size()), 23'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_instr_sequencer.md
Name: mem_instr_sequencer

Overview:
- Hardwired control sequencer for the memory-class instructions ld, ldi and st.
- Generates the per-step datapath control strobes that the DataPath bench FSM previously drove by hand: fetch steps T0–T2, then execute steps T3–T7.
- Adds a memory-ready handshake with a timeout, illegal-opcode detection and a parametrised opcode map.
- Sits between the IR opcode field and the DataPath control inputs.

Parameters:
- OPC_W, 5: opcode width (IR[31:27]).
- LD_OPC, 5'b00000: opcode of ld Ra,C(Rb).
- LDI_OPC, 5'b00001: opcode of ldi Ra,C(Rb).
- ST_OPC, 5'b00010: opcode of st C(Rb),Ra.
- TMO_W, 4: width of the memory-wait counter.
- TMO_MAX, 15: wait cycles tolerated in a memory step before error; must be ≤ 2^TMO_W−1.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous reset, active-low.
- start  in  1  begin one instruction; sampled in IDLE only.
- ir_opcode  in  OPC_W  IR[31:27]; valid from T3 onward.
- mem_ready  in  1  RAM access complete this cycle.
- PCout, MARin, IncPC, Zin, PCin  out  1 each  fetch strobes.
- ram_read, ram_write, MDRin, MDRout, IRin  out  1 each  memory/MDR strobes.
- Gra, Grb, Rin, Rout, BAout, Yin, Cout, Zlowout  out  1 each  register-file/ALU strobes.
- alu_add  out  1  ALU performs ADD.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on instruction completion.
- err_illegal  out  1  sticky; unsupported opcode seen.
- err_timeout  out  1  sticky; mem_ready timeout.

Behaviour:
- State register only; strobes are decoded combinationally from the state (Moore). Only the strobes listed for a state are 1.
- Reset (clear=0, asynchronous): state=IDLE; all strobes, busy, done and error flags = 0; wait counter = 0.
- Reset asserted mid-instruction aborts immediately with no further strobes.
- States and strobes:
  - IDLE: no strobes. start=1 → T0.
  - T0: PCout MARin IncPC Zin. → T1.
  - T1: Zlowout PCin ram_read MDRin. Hold while mem_ready=0; → T2 on mem_ready=1.
  - T2: MDRout IRin. → T3.
  - T3: Grb BAout Yin. If ir_opcode is none of the three opcodes → ERR and set err_illegal; else → T4.
  - T4: Cout alu_add Zin. → T5.
  - T5 by opcode:
    - ld/st: Zlowout MARin → T6.
    - ldi: Zlowout Gra Rin → DONE.
  - T6 by opcode:
    - ld: ram_read MDRin; hold until mem_ready → T7.
    - st: Gra Rout MDRin → T7.
  - T7 by opcode:
    - ld: MDRout Gra Rin → DONE.
    - st: ram_write; hold until mem_ready → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - ERR: no strobes, busy=1. Leaves only on reset.
- Timeout:
  - Wait counter clears on entry to each memory step (T1; T6 for ld; T7 for st) and increments each cycle mem_ready=0.
  - If the counter reaches TMO_MAX with mem_ready still 0 → ERR, set err_timeout; strobes deassert in ERR.
  - mem_ready=1 in the same cycle the counter reaches TMO_MAX counts as success.
- start while busy is ignored. start held high through DONE begins the next instruction one cycle after DONE, i.e. IDLE is always visited for one cycle.
- mem_ready outside a memory step is ignored.
- Cycle counts with mem_ready tied high, start to done pulse inclusive:
  - ld: 9 cycles.
  - st: 9 cycles.
  - ldi: 7 cycles.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: adds input step_en (1 bit).
  - Every transition out of T0–T7 additionally requires step_en=1; otherwise the state and its strobes hold.
  - Memory-step wait counters do not increment while step_en=0.
  - IDLE, DONE and ERR transitions are unaffected.
- Undefined: no step_en port; behaviour as above.

Test Plan:
- ldi, opcode 00001, mem_ready=1: start pulse → strobes T0..T5; T5 shows Zlowout Gra Rin; done on cycle 7; no ram_read asserted outside T1.
- ld, opcode 00000, mem_ready low 3 cycles in T1 and 2 cycles in T6: T1 held 4 cycles, T6 held 3 cycles, done on cycle 14; err_timeout=0.
- st, opcode 00010: T6 shows Gra Rout MDRin; T7 shows ram_write only; done pulses once; busy falls the cycle after done.
- Opcode 11111: → ERR after T3, err_illegal=1, all strobes 0, start ignored; clear=0 → IDLE, flags cleared.
- ld, mem_ready held 0 in T6 for 15 cycles → err_timeout=1, ram_read deasserts; same run with mem_ready=1 on the 15th cycle → T7 normally.
- clear pulled low asynchronously during T4 → all outputs 0 before the next clock edge; next start runs a clean T0.
